// File: rtl/priv_guard_pkg.sv
// Shared widths, defaults and record types for the privileged register access guard.
package priv_guard_pkg;
  localparam int GUARD_ADDR_W = 12;
  localparam int GUARD_PRIV_W = 2;
  localparam logic [GUARD_PRIV_W-1:0] PRIV_MAX     = '1;
  localparam logic [GUARD_PRIV_W-1:0] DEF_MIN_PRIV = PRIV_MAX;

  typedef struct packed {
    logic                    en;
    logic [GUARD_ADDR_W-1:0] base;
    logic [GUARD_ADDR_W-1:0] mask;
    logic [GUARD_PRIV_W-1:0] min_priv;
  } region_cfg_t;

  typedef struct packed {
    logic [GUARD_ADDR_W-1:0] addr;
    logic [GUARD_PRIV_W-1:0] priv;
    logic                    write;
  } fault_rec_t;

  localparam region_cfg_t REGION_RST = '{en: 1'b0, base: '0, mask: '0, min_priv: DEF_MIN_PRIV};
endpackage

// File: rtl/fault_log_fifo.sv
// Synchronous FIFO for denied-access records; an extra pointer bit separates full from empty.
module fault_log_fifo
  import priv_guard_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fault_rec_t
)(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T             r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd;
  logic         w_pop, w_push;

  assign empty  = (r_wr == r_rd);
  assign full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/priv_access_guard.sv
// Fail-closed privilege checker: region match with lowest-index priority, registered grant/fault, fault log.
module priv_access_guard
  import priv_guard_pkg::*;
#(
  parameter  int ADDR_W      = GUARD_ADDR_W,
  parameter  int PRIV_W      = GUARD_PRIV_W,
  parameter  int NUM_REGIONS = 4,
  parameter  int LOG_DEPTH   = 4,
  localparam int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [PRIV_W-1:0] priv_state,
  input  logic [ADDR_W-1:0] address,
  output logic              resp_valid,
  output logic              resp_grant,
  output logic              resp_fault,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_mask,
  input  logic [PRIV_W-1:0] cfg_min_priv,
  input  logic              cfg_lock,
  output logic              locked,
  output logic              flt_valid,
  input  logic              flt_ready,
  output logic [ADDR_W-1:0] flt_addr,
  output logic [PRIV_W-1:0] flt_priv,
  output logic              flt_write,
  output logic              flt_overflow
);
  region_cfg_t             r_cfg [NUM_REGIONS];
  logic                    r_locked, r_resp_valid, r_grant, r_fault, r_ovf;
  logic [NUM_REGIONS-1:0]  w_hit;
  logic [PRIV_W-1:0]       w_req_priv;
  logic                    w_grant, w_push, w_full, w_empty;
  fault_rec_t              w_rec, w_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGIONS; i++) r_cfg[i] <= REGION_RST;
      r_locked <= 1'b0;
    end else if (cfg_we && !r_locked) begin
      for (int i = 0; i < NUM_REGIONS; i++)
        if (cfg_idx == IDX_W'(i))
          r_cfg[i] <= '{en: cfg_en, base: cfg_base, mask: cfg_mask, min_priv: cfg_min_priv};
      if (cfg_lock) r_locked <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_match
    assign w_hit[gi] = r_cfg[gi].en &&
                       ((address & r_cfg[gi].mask) == (r_cfg[gi].base & r_cfg[gi].mask));
  end

  // Walk from the top so the lowest-index hit overwrites last; no hit keeps machine mode.
  always_comb begin
    w_req_priv = PRIV_MAX;
    for (int i = NUM_REGIONS-1; i >= 0; i--)
      if (w_hit[i]) w_req_priv = r_cfg[i].min_priv;
  end

  assign w_grant = (priv_state >= w_req_priv);
  assign w_push  = req_valid && !w_grant;
  assign w_rec   = '{addr: address, priv: priv_state, write: req_write};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_grant      <= 1'b0;
      r_fault      <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_resp_valid <= req_valid;
      r_grant      <= req_valid && w_grant;
      r_fault      <= w_push;
      if (w_push && w_full && !flt_ready) r_ovf <= 1'b1;
    end
  end

  fault_log_fifo #(.DEPTH(LOG_DEPTH), .T(fault_rec_t)) u_log (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (flt_ready),
    .din   (w_rec),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign resp_valid   = r_resp_valid;
  assign resp_grant   = r_grant;
  assign resp_fault   = r_fault;
  assign locked       = r_locked;
  assign flt_valid    = !w_empty;
  assign flt_addr     = w_head.addr;
  assign flt_priv     = w_head.priv;
  assign flt_write    = w_head.write;
  assign flt_overflow = r_ovf;
endmodule

// File: tb/tb_priv_access_guard.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based reference model.
module tb_priv_access_guard;
  localparam int NR    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid, req_write;
  logic [1:0]  priv_state;
  logic [11:0] address;
  logic        resp_valid, resp_grant, resp_fault;
  logic        cfg_we, cfg_en, cfg_lock;
  logic [1:0]  cfg_idx;
  logic [11:0] cfg_base, cfg_mask;
  logic [1:0]  cfg_min_priv;
  logic        locked, flt_valid, flt_ready, flt_write, flt_overflow;
  logic [11:0] flt_addr;
  logic [1:0]  flt_priv;

  always #5 clk = ~clk;

  priv_access_guard #(.ADDR_W(12), .PRIV_W(2), .NUM_REGIONS(NR), .LOG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .priv_state(priv_state), .address(address), .resp_valid(resp_valid),
    .resp_grant(resp_grant), .resp_fault(resp_fault), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_base(cfg_base), .cfg_mask(cfg_mask),
    .cfg_min_priv(cfg_min_priv), .cfg_lock(cfg_lock), .locked(locked),
    .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_addr(flt_addr),
    .flt_priv(flt_priv), .flt_write(flt_write), .flt_overflow(flt_overflow)
  );

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  bit          m_en  [NR];
  logic [11:0] m_base[NR], m_mask[NR];
  logic [1:0]  m_min [NR];
  bit          m_locked, m_rv, m_g, m_f, m_ovf, m_ok;
  logic [14:0] mq[$];

  function automatic logic [1:0] required(input logic [11:0] a);
    for (int i = 0; i < NR; i++)
      if (m_en[i] && (((a ^ m_base[i]) & m_mask[i]) == 12'h0)) return m_min[i];
    return 2'd3;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_en[i] = 1'b0; m_base[i] = '0; m_mask[i] = '0; m_min[i] = 2'd3;
      end
      m_locked = 0; m_rv = 0; m_g = 0; m_f = 0; m_ovf = 0;
      mq.delete();
    end else begin
      m_ok = req_valid && (priv_state >= required(address));
      m_rv = req_valid;
      m_g  = m_ok;
      m_f  = req_valid && !m_ok;
      if (flt_ready && mq.size() > 0) void'(mq.pop_front());
      if (m_f) begin
        if (mq.size() < DEPTH) mq.push_back({address, priv_state, req_write});
        else m_ovf = 1'b1;
      end
      if (cfg_we && !m_locked) begin
        m_en[cfg_idx] = cfg_en; m_base[cfg_idx] = cfg_base;
        m_mask[cfg_idx] = cfg_mask; m_min[cfg_idx] = cfg_min_priv;
        if (cfg_lock) m_locked = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("resp_valid", 32'(resp_valid), 32'(m_rv));
      chk("resp_grant", 32'(resp_grant), 32'(m_g));
      chk("resp_fault", 32'(resp_fault), 32'(m_f));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("flt_valid", 32'(flt_valid), 32'(mq.size() > 0));
      chk("flt_overflow", 32'(flt_overflow), 32'(m_ovf));
      if (mq.size() > 0) begin
        chk("flt_addr", 32'(flt_addr), 32'(mq[0][14:3]));
        chk("flt_priv", 32'(flt_priv), 32'(mq[0][2:1]));
        chk("flt_write", 32'(flt_write), 32'(mq[0][0]));
      end
    end
  end

  task automatic tick; @(posedge clk); #2; endtask

  task automatic idle;
    req_valid = 0; req_write = 0; priv_state = 0; address = 0;
    cfg_we = 0; cfg_idx = 0; cfg_en = 0; cfg_base = 0; cfg_mask = 0;
    cfg_min_priv = 0; cfg_lock = 0; flt_ready = 0;
  endtask

  task automatic req(input logic w, input logic [1:0] p, input logic [11:0] a);
    req_valid = 1; req_write = w; priv_state = p; address = a;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic en, input logic [11:0] base,
                     input logic [11:0] mask, input logic [1:0] mn, input logic lk);
    cfg_we = 1; cfg_idx = idx; cfg_en = en; cfg_base = base;
    cfg_mask = mask; cfg_min_priv = mn; cfg_lock = lk;
  endtask

  logic [11:0] masks [4] = '{12'hFFF, 12'hFF0, 12'hF00, 12'h000};

  initial begin
    idle; rst = 1; tick; tick; rst = 0; cmp_en = 1;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_flt_valid", 32'(flt_valid), 0);
    chk("rst_ovf", 32'(flt_overflow), 0);

    // No region enabled: only machine mode passes
    req(0, 2'd3, 12'h064); tick; idle;
    chk("t1_valid", 32'(resp_valid), 1);
    chk("t1_grant", 32'(resp_grant), 1);
    req(0, 2'd1, 12'h064); tick; idle;
    chk("t1_fault", 32'(resp_fault), 1);
    chk("t1_flt_addr", 32'(flt_addr), 32'h064);
    chk("t1_flt_priv", 32'(flt_priv), 1);
    chk("t1_flt_write", 32'(flt_write), 0);
    flt_ready = 1; tick; idle;
    chk("t1_popped", 32'(flt_valid), 0);

    cfg(0, 1, 12'h060, 12'hFF0, 2'd1, 0); tick; idle;
    req(1, 2'd1, 12'h064); tick; idle;
    chk("t2_grant", 32'(resp_grant), 1);
    req(1, 2'd0, 12'h064); tick; idle;
    chk("t2_fault", 32'(resp_fault), 1);
    chk("t2_flt_write", 32'(flt_write), 1);
    cfg(1, 1, 12'h064, 12'hFFF, 2'd3, 0); tick; idle;
    req(1, 2'd1, 12'h064); tick; idle;
    chk("t2_prio_grant", 32'(resp_grant), 1);
    flt_ready = 1; tick; idle;

    // Config write and request in the same cycle
    cfg(0, 1, 12'h060, 12'hFF0, 2'd2, 0); req(0, 2'd1, 12'h064); tick; idle;
    chk("t5_old_cfg", 32'(resp_grant), 1);
    req(0, 2'd1, 12'h064); tick; idle;
    chk("t5_new_cfg", 32'(resp_fault), 1);
    flt_ready = 1; tick; idle;

    for (int k = 0; k <= DEPTH; k++) begin req(0, 2'd0, 12'(32'h100 + k)); tick; end
    idle;
    chk("t4_ovf", 32'(flt_overflow), 1);
    for (int k = 0; k < DEPTH; k++) begin
      chk("t4_drain_addr", 32'(flt_addr), 32'h100 + k);
      flt_ready = 1; tick; flt_ready = 0;
    end
    chk("t4_empty", 32'(flt_valid), 0);
    rst = 1; tick; rst = 0;
    chk("t4_rst_ovf", 32'(flt_overflow), 0);
    for (int k = 0; k < DEPTH; k++) begin req(0, 2'd0, 12'(32'h200 + k)); tick; end
    req(0, 2'd0, 12'h2FF); flt_ready = 1; tick; idle;
    chk("t4_full_pop_ovf", 32'(flt_overflow), 0);
    chk("t4_full_pop_head", 32'(flt_addr), 32'h201);
    for (int k = 0; k < DEPTH; k++) begin flt_ready = 1; tick; end
    idle;

    cfg(0, 1, 12'h060, 12'hFF0, 2'd1, 1); tick; idle;
    chk("t3_locked", 32'(locked), 1);
    cfg(0, 1, 12'h060, 12'hFF0, 2'd0, 0); tick; idle;
    req(0, 2'd0, 12'h064); tick; idle;
    chk("t3_still_fault", 32'(resp_fault), 1);
    chk("t3_still_locked", 32'(locked), 1);

    req(0, 2'd0, 12'h064); tick; idle;
    rst = 1; tick; rst = 0;
    chk("t6_resp_valid", 32'(resp_valid), 0);
    chk("t6_flt_valid", 32'(flt_valid), 0);
    chk("t6_ovf", 32'(flt_overflow), 0);
    chk("t6_unlocked", 32'(locked), 0);

    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      req_valid    = ($urandom_range(0, 3) != 0);
      req_write    = 1'($urandom);
      priv_state   = 2'($urandom);
      address      = {4'h0, 8'($urandom)};
      cfg_we       = ($urandom_range(0, 7) == 0);
      cfg_idx      = 2'($urandom);
      cfg_en       = 1'($urandom);
      cfg_base     = {4'h0, 8'($urandom)};
      cfg_mask     = masks[$urandom_range(0, 3)];
      cfg_min_priv = 2'($urandom);
      cfg_lock     = cfg_we && ($urandom_range(0, 40) == 0);
      flt_ready    = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick;
    end
    idle; rst = 0; tick; tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
